// File: rtl/rpn_stack_feeder.sv
// RPN token feeder for the signed stack ALU: turns postfix tokens into stack opcodes and returns the final value with status.
// Optional idle timeout is compiled in with `define RPN_TIMEOUT_EN.
//
// state   | meaning
// ACCEPT  | waiting for a token; validates it against the tracked depth
// PUSH    | issue push of the latched operand
// ARITH   | issue add or mul
// SETTLE  | sample stack overflow flag for the arithmetic just issued
// POP     | issue final pop after a well-formed END
// CAPTURE | latch popped value into the result register
// DISCARD | error seen; drop tokens until END
// FLUSH   | pop leftover items until the stack is empty
// DONE    | result presented until the consumer takes it
module rpn_stack_feeder #(
  parameter int DATA_WIDTH     = 32,
  parameter int STACK_DEPTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [1:0]            tok_kind,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic [2:0]            stk_opcode,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_empty,
  input  logic                  stk_full,
  input  logic                  stk_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_overflow,
  output logic [2:0]            res_error,
  output logic                  busy
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  localparam logic [1:0] KIND_NUM = 2'b00;
  localparam logic [1:0] KIND_ADD = 2'b01;
  localparam logic [1:0] KIND_MUL = 2'b10;
  localparam logic [1:0] KIND_END = 2'b11;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_FULL  = 3'd2;
  localparam logic [2:0] ERR_LEFT  = 3'd3;

  typedef enum logic [3:0] {
    S_ACCEPT, S_PUSH, S_ARITH, S_SETTLE, S_POP, S_CAPTURE, S_DISCARD, S_FLUSH, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic                  is_mul_q, is_mul_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_ovf_q, res_ovf_d;
  logic [2:0]            res_err_q, res_err_d;
  logic                  ready_en_q;
  logic                  tok_fire;

  // Stack status pins are informational; depth is tracked locally.
  logic unused_inputs;
  assign unused_inputs = ^{stk_empty, stk_full};

`ifdef RPN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  function automatic logic [2:0] first_err(input logic [2:0] cur, input logic [2:0] code);
    return (cur == 3'd0) ? code : cur;
  endfunction

  assign tok_ready = ready_en_q && ((state_q == S_ACCEPT) || (state_q == S_DISCARD));
  assign tok_fire  = tok_valid && tok_ready;

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    operand_d  = operand_q;
    is_mul_d   = is_mul_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    res_err_d  = res_err_q;
    stk_opcode = OP_NOP;
`ifdef RPN_TIMEOUT_EN
    idle_d     = tok_fire ? TW'(TIMEOUT_CYCLES) : idle_q;
`endif

    case (state_q)
      S_ACCEPT: begin
        if (tok_fire) begin
          case (tok_kind)
            KIND_NUM: begin
              if (depth_q == DEPTH_FULL) begin
                res_err_d = first_err(res_err_q, ERR_FULL);
                state_d   = S_DISCARD;
              end else begin
                operand_d = tok_data;
                state_d   = S_PUSH;
              end
            end
            KIND_ADD, KIND_MUL: begin
              if (depth_q < DW'(2)) begin
                res_err_d = first_err(res_err_q, ERR_UNDER);
                state_d   = S_DISCARD;
              end else begin
                is_mul_d = (tok_kind == KIND_MUL);
                state_d  = S_ARITH;
              end
            end
            default: begin
              if (depth_q == '0) begin
                res_err_d = first_err(res_err_q, ERR_UNDER);
                state_d   = S_DONE;
              end else if (depth_q == DW'(1)) begin
                state_d = S_POP;
              end else begin
                res_err_d = first_err(res_err_q, ERR_LEFT);
                state_d   = S_FLUSH;
              end
            end
          endcase
        end
`ifdef RPN_TIMEOUT_EN
        else if ((depth_q != '0) && !tok_valid) begin
          if (idle_q == TW'(1)) begin
            res_err_d = first_err(res_err_q, 3'd4);
            state_d   = S_FLUSH;
          end else begin
            idle_d = idle_q - 1'b1;
          end
        end
`endif
      end
      S_PUSH: begin
        stk_opcode = OP_PUSH;
        depth_d    = depth_q + 1'b1;
        state_d    = S_ACCEPT;
      end
      S_ARITH: begin
        stk_opcode = is_mul_q ? OP_MUL : OP_ADD;
        depth_d    = depth_q - 1'b1;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        res_ovf_d = res_ovf_q | stk_overflow;
        state_d   = S_ACCEPT;
      end
      S_POP: begin
        stk_opcode = OP_POP;
        depth_d    = depth_q - 1'b1;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_data_d = stk_data_out;
        state_d    = S_DONE;
      end
      S_DISCARD: begin
        if (tok_fire && (tok_kind == KIND_END)) begin
          state_d = (depth_q == '0) ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        stk_opcode = OP_POP;
        depth_d    = depth_q - 1'b1;
        res_data_d = '0;
        if (depth_q == DW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_data_d = '0;
          res_ovf_d  = 1'b0;
          res_err_d  = 3'd0;
          depth_d    = '0;
          state_d    = S_ACCEPT;
`ifdef RPN_TIMEOUT_EN
          idle_d     = TW'(TIMEOUT_CYCLES);
`endif
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ACCEPT;
      depth_q    <= '0;
      operand_q  <= '0;
      is_mul_q   <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_err_q  <= 3'd0;
      ready_en_q <= 1'b0;
`ifdef RPN_TIMEOUT_EN
      idle_q     <= TW'(TIMEOUT_CYCLES);
`endif
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      operand_q  <= operand_d;
      is_mul_q   <= is_mul_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_err_q  <= res_err_d;
      ready_en_q <= 1'b1;
`ifdef RPN_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign stk_data_in  = operand_q;
  assign res_valid    = (state_q == S_DONE);
  assign res_data     = res_data_q;
  assign res_overflow = res_ovf_q;
  assign res_error    = res_err_q;
  assign busy         = !((state_q == S_ACCEPT) && (depth_q == '0));

endmodule

// File: doc/rpn_stack_feeder.md
Name: rpn_stack_feeder

Overview:
- Upstream controller for the signed stack ALU (opcodes 110 push, 111 pop, 100 add, 101 mul).
- Accepts a stream of postfix (RPN) tokens over a valid/ready handshake and issues one stack opcode per operation.
- Tracks stack depth locally, detects malformed expressions, and collects overflow.
- On an END token, pops the final value and presents it with status on a valid/ready result port.

Parameters:
DATA_WIDTH, 32, operand/result width (signed two's complement)
STACK_DEPTH, 16, depth of the attached stack; must match the stack instance
TIMEOUT_CYCLES, 64, idle-cycle limit (used only with RPN_TIMEOUT_EN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
tok_valid  in  1  token present
tok_ready  out  1  feeder accepts token this cycle
tok_kind  in  2  00 number, 01 add, 10 mul, 11 end
tok_data  in  DATA_WIDTH  operand (number tokens only)
stk_opcode  out  3  to stack; 000 = nop
stk_data_in  out  DATA_WIDTH  push operand to stack
stk_data_out  in  DATA_WIDTH  stack top/result, valid cycle after op
stk_empty  in  1  stack empty (informational; feeder uses own depth count)
stk_full  in  1  stack full (informational)
stk_overflow  in  1  arithmetic overflow, valid cycle after add/mul issue
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_data  out  DATA_WIDTH  final value (0 on error)
res_overflow  out  1  sticky OR of overflow over the expression
res_error  out  3  0 ok, 1 underflow, 2 stack full, 3 leftover operands, 4 timeout
busy  out  1  high in every state except ACCEPT with depth 0

Behaviour:
- Reset (async, rst_n low):
  - State ACCEPT, depth 0, tok_ready 0.
  - stk_opcode 000, stk_data_in 0.
  - res_valid 0, res_data 0, res_overflow 0, res_error 0, busy 0.
  - tok_ready rises in the first cycle after deassertion.
  - Stack shares the same reset; after reset the feeder treats the stack as empty.
- Reset mid-expression: abandon everything, with no flush pops.
- Handshake: a token transfers on the rising edge where tok_valid and tok_ready are both high. tok_ready = 1 only in ACCEPT and DISCARD.
- stk_opcode is nonzero for exactly one cycle per operation, and 000 otherwise.
- FSM states:
  - ACCEPT
    - number: if depth == STACK_DEPTH, set error 2 and go to DISCARD. Else latch tok_data and go to PUSH.
    - add/mul: if depth < 2, set error 1 and go to DISCARD. Else go to ARITH.
    - end: depth 0 sets error 1 and goes to DONE. Depth > 1 sets error 3 and goes to FLUSH. Depth 1 goes to POP.
  - PUSH: stk_opcode 110, stk_data_in = latched operand; depth += 1; go to ACCEPT.
  - ARITH: stk_opcode 100/101; depth -= 1; go to SETTLE.
  - SETTLE: res_overflow |= stk_overflow; go to ACCEPT.
  - POP: stk_opcode 111; depth -= 1; go to CAPTURE.
  - CAPTURE: res_data = stk_data_out; go to DONE.
  - DISCARD: consume and drop tokens until an end token is accepted, then go to FLUSH (or DONE if depth 0).
  - FLUSH: stk_opcode 111 each cycle, depth -= 1, until depth 0; then go to DONE. res_data forced to 0.
  - DONE: res_valid = 1, outputs held stable until res_ready. On the handshake, clear res_* and go to ACCEPT with depth 0.
- Latency from token acceptance to the next tok_ready:
  - number 2 cycles.
  - add/mul 3 cycles.
  - end to res_valid 3 cycles (ACCEPT, POP, CAPTURE, DONE).
- Only the first error is recorded; later errors within the same expression are ignored.
- res_overflow is reported even with error 0. Overflowed results still deliver the wrapped stack value.
- Depth counter width is clog2(STACK_DEPTH+1). It never underflows or overflows, by construction of the checks above.

Optional Feature:
- Macro: RPN_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ACCEPT while depth > 0 and tok_valid is low.
  - The counter resets on any accepted token.
  - On reaching TIMEOUT_CYCLES: set error 4 (if no earlier error) and go to FLUSH; no end token is required.
  - DISCARD is not timed.
- Undefined: no counter. The feeder waits indefinitely and code 4 never appears.

Test Plan:
- Tokens 3, 5, add, end with tok_valid held high and res_ready high -> opcodes 110, 110, 100, 111 in that order; res_data 8, res_overflow 0, res_error 0; res_valid asserts 3 cycles after end is accepted.
- Tokens 2147483647, 2, add, end -> res_data -2147483647, res_overflow 1, res_error 0. Tokens 65536, 65536, mul, end -> res_overflow 1. Tokens -20000, -5000, mul, end -> res_data 100000000, res_overflow 0.
- Tokens 7, add, 4, end -> error 1 at add; token 4 discarded (no push issued); one flush pop; res_error 1, res_data 0.
- 17 number tokens (1..17), then end -> 16 pushes, 17th rejected with error 2; 16 flush pops; res_error 2, depth returns to 0.
- Tokens 1, 2, end -> one pop per remaining item; res_error 3. Then rst_n pulsed low mid-expression after tokens 9, 9 -> all outputs at reset values, and next expression 4, 6, mul, end -> res_data 24.
- With RPN_TIMEOUT_EN, TIMEOUT_CYCLES=8: token 5 then tok_valid low -> after 8 idle cycles, one flush pop, res_error 4. Without the macro -> busy stays high and no result appears.
